// File: rtl/mul_iter.sv
// ---------------------------------------------------------------------------
// mul_iter: iterative radix-4 Booth multiplier shared by MUL/MULH in execute.
//
// Retires DIGITS_PER_CYCLE Booth digits per clock into a registered
// accumulator.  Each operand's signedness is chosen per request.  The result
// is held until the consumer accepts it.
//
// Parameters
//   XLEN              operand width (even, >= 8)
//   DIGITS_PER_CYCLE  Booth digits retired per iteration (1 .. XLEN/2+1)
//
// Ports
//   clk              clock, rising edge
//   reset_n          asynchronous active-low reset
//   req_valid        request present
//   req_ready        block can accept a request this cycle
//   req_in_1_signed  req_in_1 is two's complement
//   req_in_2_signed  req_in_2 is two's complement
//   req_in_1         multiplier (Booth-recoded operand)
//   req_in_2         multiplicand
//   resp_valid       resp_result is valid
//   resp_ready       consumer takes the result this cycle
//   resp_result      full 2*XLEN product
//
// Build option
//   MUL_EARLY_OUT_EN  when defined, the block finishes as soon as every
//                     remaining Booth digit is zero (minimum latency 1).
// ---------------------------------------------------------------------------
module mul_iter #(
    parameter int XLEN             = 32,
    parameter int DIGITS_PER_CYCLE = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_in_1_signed,
    input  logic                req_in_2_signed,
    input  logic [XLEN-1:0]     req_in_1,
    input  logic [XLEN-1:0]     req_in_2,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [2*XLEN-1:0]   resp_result
);

    localparam int ND = XLEN / 2 + 1;
    localparam int C  = (ND + DIGITS_PER_CYCLE - 1) / DIGITS_PER_CYCLE;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    // Multiplier register layout: {ext, ext, x[XLEN-1:0], x[-1]=0}
    localparam int XW = XLEN + 3;
    // Partial-product width: sign-extended +/-2y
    localparam int PW = XLEN + 2;
    localparam int RW = 2 * XLEN;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [XLEN:0]     y_q, y_d;
    logic [RW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              handshake;
    logic [RW-1:0]     iterSum;
    logic [XW-1:0]     xShifted;
    logic              lastIter;
    logic              earlyOut;

    assign req_ready   = (state_q == IDLE) || (state_q == DONE && resp_ready);
    assign handshake   = req_valid && req_ready;
    assign resp_valid  = (state_q == DONE);
    assign resp_result = acc_q;

    // The multiplier register is consumed from the bottom and refilled with
    // its extension bit, so after shifting, bit 0 is the boundary bit of the
    // next digit group.
    assign xShifted = $signed(x_q) >>> (2 * DIGITS_PER_CYCLE);
    assign lastIter = (cnt_q == CW'(C - 1));

`ifdef MUL_EARLY_OUT_EN
    // All remaining triplets are 000 or 111 exactly when every remaining
    // multiplier bit, boundary bit included, has the same value.
    assign earlyOut = (&xShifted) || (~|xShifted);
`else
    assign earlyOut = 1'b0;
`endif

    // One iteration: add DIGITS_PER_CYCLE Booth partial products, each
    // shifted to its digit weight 4^k.  Negative digits are added as the
    // inverted magnitude plus a +1 injected at the digit's LSB.
    always_comb begin : booth_sum
        logic [2:0]    trip;
        logic [PW-1:0] mag;
        logic [PW-1:0] magX;
        logic          neg;
        logic          nonZero;
        int            digitIdx;
        logic [RW-1:0] term;
        logic [RW-1:0] carryIn;

        iterSum  = acc_q;
        trip     = '0;
        mag      = '0;
        magX     = '0;
        neg      = 1'b0;
        nonZero  = 1'b0;
        digitIdx = 0;
        term     = '0;
        carryIn  = '0;
        for (int j = 0; j < DIGITS_PER_CYCLE; j++) begin
            trip     = x_q[2*j +: 3];
            digitIdx = int'(cnt_q) * DIGITS_PER_CYCLE + j;
            neg      = 1'b0;
            nonZero  = 1'b1;
            mag      = {y_q[XLEN], y_q};
            case (trip)
                3'b000, 3'b111: nonZero = 1'b0;
                3'b001, 3'b010: mag = {y_q[XLEN], y_q};
                3'b011:         mag = {y_q, 1'b0};
                3'b100: begin
                    mag = {y_q, 1'b0};
                    neg = 1'b1;
                end
                default:        neg = 1'b1;
            endcase
            if (digitIdx >= ND) begin
                nonZero = 1'b0;
            end
            if (nonZero) begin
                magX    = neg ? ~mag : mag;
                term    = {{(RW-PW){magX[PW-1]}}, magX};
                carryIn = {{(RW-1){1'b0}}, neg};
                iterSum = iterSum + (term << (2 * digitIdx))
                                  + (carryIn << (2 * digitIdx));
            end
        end
    end

    // Next-state logic.  A handshake in IDLE or DONE loads the extended
    // operands and clears the accumulator and digit counter; BUSY folds in
    // one group of digits per cycle.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (handshake) begin
                    x_d     = {{2{req_in_1_signed & req_in_1[XLEN-1]}},
                               req_in_1, 1'b0};
                    y_d     = {req_in_2_signed & req_in_2[XLEN-1], req_in_2};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else if (state_q == DONE && resp_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                acc_d = iterSum;
                x_d   = xShifted;
                cnt_d = cnt_q + CW'(1);
                if (lastIter || earlyOut) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mul_iter.sv
// ---------------------------------------------------------------------------
// tb_mul_iter: directed self-checking bench for mul_iter.
// Main instance: XLEN=32, DIGITS_PER_CYCLE=4 (5 iterations).
// Extra instances: XLEN=16/D=1 and XLEN=32/D=17, each swept with random
// operands against a plain modular-multiply reference.
// ---------------------------------------------------------------------------
module tb_mul_iter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    // Main instance signals
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        s1 = 1'b0;
    logic        s2 = 1'b0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        respValid;
    logic        respReady = 1'b0;
    logic [63:0] result;

    // Narrow instance signals (XLEN=16, one digit per cycle)
    logic        nReqValid = 1'b0;
    logic        nReqReady;
    logic        nS1 = 1'b0;
    logic        nS2 = 1'b0;
    logic [15:0] nIn1 = '0;
    logic [15:0] nIn2 = '0;
    logic        nRespValid;
    logic        nRespReady = 1'b0;
    logic [31:0] nResult;

    // Wide instance signals (XLEN=32, all digits in one cycle)
    logic        wReqValid = 1'b0;
    logic        wReqReady;
    logic        wS1 = 1'b0;
    logic        wS2 = 1'b0;
    logic [31:0] wIn1 = '0;
    logic [31:0] wIn2 = '0;
    logic        wRespValid;
    logic        wRespReady = 1'b0;
    logic [63:0] wResult;

    int nVectors = 0;
    int nMiscompares = 0;

    mul_iter #(.XLEN(32), .DIGITS_PER_CYCLE(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(reqValid), .req_ready(reqReady),
        .req_in_1_signed(s1), .req_in_2_signed(s2),
        .req_in_1(in1), .req_in_2(in2),
        .resp_valid(respValid), .resp_ready(respReady),
        .resp_result(result)
    );

    mul_iter #(.XLEN(16), .DIGITS_PER_CYCLE(1)) dutNarrow (
        .clk(clk), .reset_n(reset_n),
        .req_valid(nReqValid), .req_ready(nReqReady),
        .req_in_1_signed(nS1), .req_in_2_signed(nS2),
        .req_in_1(nIn1), .req_in_2(nIn2),
        .resp_valid(nRespValid), .resp_ready(nRespReady),
        .resp_result(nResult)
    );

    mul_iter #(.XLEN(32), .DIGITS_PER_CYCLE(17)) dutWide (
        .clk(clk), .reset_n(reset_n),
        .req_valid(wReqValid), .req_ready(wReqReady),
        .req_in_1_signed(wS1), .req_in_2_signed(wS2),
        .req_in_1(wIn1), .req_in_2(wIn2),
        .resp_valid(wRespValid), .resp_ready(wRespReady),
        .resp_result(wResult)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Safety net so the run always ends even if a handshake wedges
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present one request to the main instance; it must be accepted on the
    // next rising edge.  Returns #1 after that edge with req_valid dropped.
    task automatic issueMain(input logic [31:0] a, input logic [31:0] b,
                             input logic sa, input logic sb);
        @(negedge clk);
        in1      = a;
        in2      = b;
        s1       = sa;
        s2       = sb;
        reqValid = 1'b1;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    // Count rising edges from the handshake until resp_valid, bounded.
    task automatic waitMain(output int lat);
        lat = 0;
        while (!respValid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Accept the pending response for one cycle.
    task automatic takeMain;
        respReady = 1'b1;
        @(posedge clk);
        #1;
        respReady = 1'b0;
    endtask

    // Reset values are visible while reset is held and just after release.
    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        nVectors++;
        if (reqReady !== 1'b1 || respValid !== 1'b0 || result !== 64'h0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_state: ready=%b valid=%b result=%h, want 1 0 0",
                     reqReady, respValid, result);
        end
        reset_n = 1'b1;
        @(negedge clk);
        nVectors++;
        if (reqReady !== 1'b1 || respValid !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL after_reset: ready=%b valid=%b, want 1 0",
                     reqReady, respValid);
        end
    endtask

    // Largest unsigned operands; also pins the fixed 5-cycle latency and the
    // response being held while the consumer is not ready.
    task automatic test_unsigned_max;
        int lat;
        issueMain(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        waitMain(lat);
        nVectors++;
        if (lat != 5) begin
            nMiscompares++;
            $display("[TB] FAIL umax_latency: got %0d cycles, want 5", lat);
        end
        nVectors++;
        if (result !== 64'hFFFF_FFFE_0000_0001) begin
            nMiscompares++;
            $display("[TB] FAIL umax_result: got %h, want fffffffe00000001", result);
        end
        nVectors++;
        if (reqReady !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL done_not_ready: req_ready=%b, want 0", reqReady);
        end
        takeMain();
        nVectors++;
        if (respValid !== 1'b0 || reqReady !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL resp_drop: valid=%b ready=%b, want 0 1",
                     respValid, reqReady);
        end
    endtask

    // -1 * -1 with both operands signed
    task automatic test_signed_max;
        int lat;
        issueMain(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        waitMain(lat);
        nVectors++;
        if (respValid !== 1'b1 || result !== 64'h0000_0000_0000_0001) begin
            nMiscompares++;
            $display("[TB] FAIL smax_result: valid=%b got %h, want 1 0000000000000001",
                     respValid, result);
        end
        takeMain();
    endtask

    // -2^31 (signed) * (2^32-1) (unsigned) = 2^63 + 2^31 mod 2^64
    task automatic test_mixed;
        int lat;
        issueMain(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        waitMain(lat);
        nVectors++;
        if (respValid !== 1'b1 || result !== 64'h8000_0000_8000_0000) begin
            nMiscompares++;
            $display("[TB] FAIL mixed_result: valid=%b got %h, want 1 8000000080000000",
                     respValid, result);
        end
        takeMain();
    endtask

    // Result must hold under back-pressure; releasing it together with a
    // new request must start the next multiply in that same cycle.
    task automatic test_back_pressure;
        int lat;
        logic held;
        issueMain(32'h0001_0001, 32'h0001_0001, 1'b0, 1'b0);
        waitMain(lat);
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (respValid !== 1'b1 || reqReady !== 1'b0 ||
                result !== 64'h0000_0001_0002_0001) begin
                held = 1'b0;
            end
        end
        nVectors++;
        if (!held) begin
            nMiscompares++;
            $display("[TB] FAIL bp_hold: valid=%b ready=%b result=%h, want 1 0 0000000100020001",
                     respValid, reqReady, result);
        end
        respReady = 1'b1;
        reqValid  = 1'b1;
        in1       = 32'hFFFF_FFFF;
        in2       = 32'h0000_0002;
        s1        = 1'b0;
        s2        = 1'b0;
        #1;
        nVectors++;
        if (reqReady !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL bp_same_cycle_ready: req_ready=%b, want 1", reqReady);
        end
        @(posedge clk);
        #1;
        reqValid  = 1'b0;
        respReady = 1'b0;
        waitMain(lat);
        nVectors++;
        if (lat != 5 || result !== 64'h0000_0001_FFFF_FFFE) begin
            nMiscompares++;
            $display("[TB] FAIL bp_next: latency %0d result %h, want 5 00000001fffffffe",
                     lat, result);
        end
        takeMain();
    endtask

    // Reset in the third BUSY cycle abandons the multiply with no response.
    task automatic test_reset_abort;
        int lat;
        logic quiet;
        issueMain(32'd7, 32'd9, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        nVectors++;
        if (respValid !== 1'b0 || reqReady !== 1'b1 || result !== 64'h0) begin
            nMiscompares++;
            $display("[TB] FAIL abort_in_reset: valid=%b ready=%b result=%h, want 0 1 0",
                     respValid, reqReady, result);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        nVectors++;
        if (reqReady !== 1'b1) begin
            nMiscompares++;
            $display("[TB] FAIL abort_ready: req_ready=%b, want 1", reqReady);
        end
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (respValid !== 1'b0) quiet = 1'b0;
        end
        nVectors++;
        if (!quiet) begin
            nMiscompares++;
            $display("[TB] FAIL abort_no_resp: resp_valid rose %b, want 0", ~quiet);
        end
        issueMain(32'd7, 32'd9, 1'b0, 1'b0);
        waitMain(lat);
        nVectors++;
        if (respValid !== 1'b1 || result !== 64'h3F) begin
            nMiscompares++;
            $display("[TB] FAIL abort_retry: valid=%b got %h, want 1 000000000000003f",
                     respValid, result);
        end
        takeMain();
    endtask

    // Small multiplier: only the first digit group is non-zero.
    task automatic test_early_out;
        int lat;
        int wantLat;
`ifdef MUL_EARLY_OUT_EN
        wantLat = 1;
`else
        wantLat = 5;
`endif
        issueMain(32'd3, 32'h1234_5678, 1'b0, 1'b0);
        waitMain(lat);
        nVectors++;
        if (lat != wantLat) begin
            nMiscompares++;
            $display("[TB] FAIL early_latency: got %0d cycles, want %0d", lat, wantLat);
        end
        nVectors++;
        if (result !== 64'h0000_0000_369D_0368) begin
            nMiscompares++;
            $display("[TB] FAIL early_result: got %h, want 00000000369d0368", result);
        end
        takeMain();
    endtask

    // XLEN=16, one digit per cycle, random operands and signedness.
    task automatic test_sweep_narrow;
        logic [31:0] a32;
        logic [31:0] b32;
        logic [31:0] want;
        int lat;
        int wantLat;
`ifdef MUL_EARLY_OUT_EN
        wantLat = -1;
`else
        wantLat = 9;
`endif
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            nIn1      = 16'($urandom);
            nIn2      = 16'($urandom);
            nS1       = 1'($urandom);
            nS2       = 1'($urandom);
            nReqValid = 1'b1;
            @(posedge clk);
            #1;
            nReqValid = 1'b0;
            lat = 0;
            while (!nRespValid && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
            end
            a32  = nS1 ? {{16{nIn1[15]}}, nIn1} : {16'h0, nIn1};
            b32  = nS2 ? {{16{nIn2[15]}}, nIn2} : {16'h0, nIn2};
            want = a32 * b32;
            nVectors++;
            if (nRespValid !== 1'b1 || nResult !== want ||
                (wantLat > 0 && lat != wantLat)) begin
                nMiscompares++;
                $display("[TB] FAIL narrow_sweep: %h(%b)*%h(%b) got %h lat %0d, want %h",
                         nIn1, nS1, nIn2, nS2, nResult, lat, want);
            end
            nRespReady = 1'b1;
            @(posedge clk);
            #1;
            nRespReady = 1'b0;
        end
    endtask

    // XLEN=32 with every digit retired in a single iteration.
    task automatic test_sweep_wide;
        logic [63:0] a64;
        logic [63:0] b64;
        logic [63:0] want;
        int lat;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            wIn1      = $urandom;
            wIn2      = $urandom;
            wS1       = 1'($urandom);
            wS2       = 1'($urandom);
            wReqValid = 1'b1;
            @(posedge clk);
            #1;
            wReqValid = 1'b0;
            lat = 0;
            while (!wRespValid && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
            end
            a64  = wS1 ? {{32{wIn1[31]}}, wIn1} : {32'h0, wIn1};
            b64  = wS2 ? {{32{wIn2[31]}}, wIn2} : {32'h0, wIn2};
            want = a64 * b64;
            nVectors++;
            if (wRespValid !== 1'b1 || wResult !== want || lat != 1) begin
                nMiscompares++;
                $display("[TB] FAIL wide_sweep: %h(%b)*%h(%b) got %h lat %0d, want %h",
                         wIn1, wS1, wIn2, wS2, wResult, lat, want);
            end
            wRespReady = 1'b1;
            @(posedge clk);
            #1;
            wRespReady = 1'b0;
        end
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_max();
        test_mixed();
        test_back_pressure();
        test_reset_abort();
        test_early_out();
        test_sweep_narrow();
        test_sweep_wide();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
